// File: rtl/sync_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Package : sync_pkg                                                    |
// | Shared edge-mode encoding, minimum synchroniser depth and the         |
// | per-channel edge qualification helper for the sync_edge_bank slice.   |
// | Revision: 1.0  initial release                                        |
// +----------------------------------------------------------------------+
package sync_pkg;

  typedef enum logic [1:0] {
    EDGE_NONE = 2'b00,
    EDGE_RISE = 2'b01,
    EDGE_FALL = 2'b10,
    EDGE_BOTH = 2'b11
  } edge_mode_e;

  localparam int SYNC_MIN_STAGES = 2;

  // Bit 0 of the mode enables rising edges, bit 1 enables falling edges.
  function automatic logic edge_hit(input logic [1:0] mode,
                                    input logic       lvl,
                                    input logic       prev);
    return (lvl & ~prev & mode[0]) | (~lvl & prev & mode[1]);
  endfunction

endpackage
`default_nettype wire

// File: rtl/sync_chain.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module  : sync_chain                                                  |
// | One-bit, STAGES-deep flop synchroniser. Pure flop chain with no logic |
// | between stages so CDC tools recognise it by instance name.            |
// | Revision: 1.0  initial release                                        |
// +----------------------------------------------------------------------+
module sync_chain
  import sync_pkg::*;
#(
  parameter int   STAGES  = 2,
  parameter logic RST_VAL = 1'b0
) (
  input  logic clk,
  input  logic rst_n,
  input  logic d,
  output logic q
);

  // Fewer than two stages gives no metastability protection at all.
  if (STAGES < SYNC_MIN_STAGES) begin : g_bad_stages
    $error("sync_chain: STAGES must be at least %0d", SYNC_MIN_STAGES);
  end

  logic [STAGES-1:0] r_stage;

  // Shift the asynchronous input through the chain; stage 0 is the capture flop.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_stage <= {STAGES{RST_VAL}};
    end else begin
      r_stage <= {r_stage[STAGES-2:0], d};
    end
  end

  assign q = r_stage[STAGES-1];

endmodule
`default_nettype wire

// File: rtl/sync_edge_bank.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module  : sync_edge_bank                                              |
// | CH-channel synchroniser bank with per-channel programmable edge       |
// | detection, one-cycle event pulses and sticky event flags.             |
// | Optional debounce filter enabled by macro SYNC_EDGE_BANK_FILTER_EN.   |
// | Revision: 1.0  initial release                                        |
// +----------------------------------------------------------------------+
module sync_edge_bank
  import sync_pkg::*;
#(
  parameter int   CH      = 4,
  parameter int   STAGES  = 2,
  parameter logic RST_VAL = 1'b0,
  parameter int   FILT_W  = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [CH-1:0]     async_in,
  input  logic [2*CH-1:0]   edge_mode,
  input  logic [FILT_W-1:0] filt_len,
  input  logic [CH-1:0]     event_clr,
  output logic [CH-1:0]     sync_out,
  output logic [CH-1:0]     edge_pulse,
  output logic [CH-1:0]     event_flag
);

  logic [CH-1:0] w_sync;
  logic [CH-1:0] w_lvl;
  logic [CH-1:0] w_hit;
  logic [CH-1:0] r_prev;
  logic [CH-1:0] r_pulse;
  logic [CH-1:0] r_flag;

  for (genvar c = 0; c < CH; c++) begin : g_ch
    sync_chain #(
      .STAGES  (STAGES),
      .RST_VAL (RST_VAL)
    ) u_sync_chain (
      .clk   (clk),
      .rst_n (rst_n),
      .d     (async_in[c]),
      .q     (w_sync[c])
    );
  end

`ifdef SYNC_EDGE_BANK_FILTER_EN
  logic [CH-1:0]     r_lvl;
  logic [FILT_W-1:0] r_cnt [CH];

  // Debounce: the level follows only after filt_len+1 consecutive differing samples.
  // The >= compare keeps the counter bounded if filt_len is lowered mid-count.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_lvl <= {CH{RST_VAL}};
      for (int c = 0; c < CH; c++) begin
        r_cnt[c] <= '0;
      end
    end else begin
      for (int c = 0; c < CH; c++) begin
        if (w_sync[c] == r_lvl[c]) begin
          r_cnt[c] <= '0;
        end else if (r_cnt[c] >= filt_len) begin
          r_lvl[c] <= w_sync[c];
          r_cnt[c] <= '0;
        end else begin
          r_cnt[c] <= r_cnt[c] + FILT_W'(1);
        end
      end
    end
  end

  assign w_lvl = r_lvl;
`else
  // Without the filter the last sync stage is already a register and is the level.
  logic w_unused_filt;
  assign w_unused_filt = ^filt_len;
  assign w_lvl         = w_sync;
`endif

  // Qualify level changes against each channel's edge mode.
  always_comb begin
    w_hit = '0;
    for (int c = 0; c < CH; c++) begin
      w_hit[c] = edge_hit(edge_mode[2*c +: 2], w_lvl[c], r_prev[c]);
    end
  end

  // Level history, registered pulse and sticky flag (set beats clear).
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_prev  <= {CH{RST_VAL}};
      r_pulse <= '0;
      r_flag  <= '0;
    end else begin
      r_prev  <= w_lvl;
      r_pulse <= w_hit;
      r_flag  <= (r_flag & ~event_clr) | r_pulse;
    end
  end

  assign sync_out   = w_lvl;
  assign edge_pulse = r_pulse;
  assign event_flag = r_flag;

endmodule
`default_nettype wire

// File: tb/tb_sync_edge_bank.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module  : tb_sync_edge_bank                                           |
// | Scoreboard bench for sync_edge_bank: a delay-line reference model     |
// | predicts every cycle, a negedge monitor pops and compares.            |
// | Revision: 1.0  initial release                                        |
// +----------------------------------------------------------------------+
module tb_sync_edge_bank;
  import sync_pkg::*;

  localparam int   CH      = 4;
  localparam int   STAGES  = 2;
  localparam int   FILT_W  = 4;
  localparam logic RST_VAL = 1'b0;
`ifdef SYNC_EDGE_BANK_FILTER_EN
  localparam bit   FILT    = 1'b1;
`else
  localparam bit   FILT    = 1'b0;
`endif

  logic              clk       = 1'b0;
  logic              rst_n     = 1'b0;
  logic [CH-1:0]     async_in  = '0;
  logic [2*CH-1:0]   edge_mode = '0;
  logic [FILT_W-1:0] filt_len  = '0;
  logic [CH-1:0]     event_clr = '0;
  logic [CH-1:0]     sync_out;
  logic [CH-1:0]     edge_pulse;
  logic [CH-1:0]     event_flag;

  always #5 clk = ~clk;

  sync_edge_bank #(
    .CH      (CH),
    .STAGES  (STAGES),
    .RST_VAL (RST_VAL),
    .FILT_W  (FILT_W)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .async_in   (async_in),
    .edge_mode  (edge_mode),
    .filt_len   (filt_len),
    .event_clr  (event_clr),
    .sync_out   (sync_out),
    .edge_pulse (edge_pulse),
    .event_flag (event_flag)
  );

  typedef struct packed {
    logic [CH-1:0] lvl;
    logic [CH-1:0] pulse;
    logic [CH-1:0] flag;
  } exp_t;

  exp_t sb_q[$];
  int   n_checks = 0;
  int   n_pass   = 0;

  // Reference model: inputs sampled at each edge travel down a queue;
  // the synchronised level is the sample taken STAGES-1 edges earlier.
  logic [CH-1:0] m_dl[$];
  logic [CH-1:0] m_lvl, m_prev, m_pulse, m_flag;
  int            m_run [CH];

  task automatic model_reset();
    m_dl.delete();
    for (int i = 0; i < STAGES; i++) m_dl.push_back({CH{RST_VAL}});
    m_lvl   = {CH{RST_VAL}};
    m_prev  = {CH{RST_VAL}};
    m_pulse = '0;
    m_flag  = '0;
    for (int c = 0; c < CH; c++) m_run[c] = 0;
  endtask

  task automatic model_edge();
    logic [CH-1:0] s_pre, n_lvl, n_pulse, n_flag;
    logic [1:0]    md;
    if (!rst_n) begin
      model_reset();
      return;
    end
    s_pre  = m_dl[0];
    n_flag = (m_flag & ~event_clr) | m_pulse;
    for (int c = 0; c < CH; c++) begin
      md         = edge_mode[2*c +: 2];
      n_pulse[c] = ((m_lvl[c] == 1'b1) && (m_prev[c] == 1'b0) && md[0]) ||
                   ((m_lvl[c] == 1'b0) && (m_prev[c] == 1'b1) && md[1]);
    end
    m_dl.push_back(async_in);
    void'(m_dl.pop_front());
    n_lvl = m_lvl;
    if (FILT) begin
      for (int c = 0; c < CH; c++) begin
        if (s_pre[c] == m_lvl[c]) begin
          m_run[c] = 0;
        end else if (m_run[c] >= int'(filt_len)) begin
          n_lvl[c] = s_pre[c];
          m_run[c] = 0;
        end else begin
          m_run[c] = m_run[c] + 1;
        end
      end
    end else begin
      n_lvl = m_dl[0];
    end
    m_prev  = m_lvl;
    m_lvl   = n_lvl;
    m_pulse = n_pulse;
    m_flag  = n_flag;
  endtask

  // One clock: predict the state after this edge, queue it, then leave the edge.
  task automatic cycle();
    exp_t e;
    @(posedge clk);
    model_edge();
    e.lvl   = m_lvl;
    e.pulse = m_pulse;
    e.flag  = m_flag;
    sb_q.push_back(e);
    #1;
  endtask

  task automatic cycles(input int n);
    for (int i = 0; i < n; i++) cycle();
  endtask

  task automatic check(input string name, input logic [CH-1:0] act, input logic [CH-1:0] req);
    n_checks++;
    if (act === req) n_pass++;
    else $display("FAIL %s t=%0t actual=%h required=%h", name, $time, act, req);
  endtask

  // Monitor: outputs are valid every cycle; reset overrides any queued prediction.
  always @(negedge clk) begin
    exp_t e;
    if (sb_q.size() > 0) begin
      e = sb_q.pop_front();
      if (!rst_n) begin
        e.lvl   = {CH{RST_VAL}};
        e.pulse = '0;
        e.flag  = '0;
      end
      check("sync_out",   sync_out,   e.lvl);
      check("edge_pulse", edge_pulse, e.pulse);
      check("event_flag", event_flag, e.flag);
    end
  end

  function automatic logic [2*CH-1:0] modes(input edge_mode_e m3, input edge_mode_e m2,
                                            input edge_mode_e m1, input edge_mode_e m0);
    return {m3, m2, m1, m0};
  endfunction

  initial begin
    int k;
    model_reset();

    // Reset with all inputs high, mixed modes.
    async_in  = 4'hF;
    edge_mode = modes(EDGE_RISE, EDGE_FALL, EDGE_BOTH, EDGE_RISE);
    cycles(3);
    rst_n = 1'b1;
    cycles(8);

    // Latency of a single-channel rise with all modes on both edges.
    edge_mode = modes(EDGE_BOTH, EDGE_BOTH, EDGE_BOTH, EDGE_BOTH);
    async_in  = 4'h0;
    cycles(8);
    async_in[2] = 1'b1;
    cycles(8);

    // Mode filtering: ch0 rise only, ch1 fall only, others off.
    edge_mode = modes(EDGE_NONE, EDGE_NONE, EDGE_FALL, EDGE_RISE);
    async_in  = 4'h3;
    cycles(8);
    async_in  = 4'h0;
    cycles(8);

    // Clear colliding with the pulse, then a plain clear.
    edge_mode   = modes(EDGE_BOTH, EDGE_BOTH, EDGE_BOTH, EDGE_BOTH);
    async_in[3] = 1'b1;
    k = 0;
    while (!m_pulse[3] && k < 30) begin
      cycle();
      k++;
    end
    if (k == 30) begin
      n_checks++;
      $display("FAIL clr_wait t=%0t actual=timeout required=pulse_on_ch3", $time);
    end
    event_clr[3] = 1'b1;
    cycle();
    cycle();
    event_clr[3] = 1'b0;
    cycles(4);

    // Glitch of 3 cycles then a stable high of 4+ cycles on ch1.
    filt_len    = 4'd3;
    async_in[1] = 1'b1;
    cycles(3);
    async_in[1] = 1'b0;
    cycles(10);
    async_in[1] = 1'b1;
    cycles(12);
    filt_len    = 4'd0;
    async_in[1] = 1'b0;
    cycles(8);

    // Mid-operation reset with flags set, asserted between edges.
    async_in = 4'hA;
    cycles(10);
    async_in = 4'h5;
    cycle();
    cycle();
    rst_n = 1'b0;
    cycles(2);
    rst_n = 1'b1;
    cycles(8);

    // Randomised traffic with occasional mode/filter changes and one reset.
    for (int i = 0; i < 800; i++) begin
      if ($urandom_range(0, 2) == 0) async_in = async_in ^ CH'($urandom);
      if ($urandom_range(0, 40) == 0) edge_mode = (2*CH)'($urandom);
      if ($urandom_range(0, 60) == 0) filt_len = FILT_W'($urandom_range(0, 4));
      event_clr = ($urandom_range(0, 3) == 0) ? CH'($urandom) : '0;
      if (i == 400) rst_n = 1'b0;
      if (i == 403) rst_n = 1'b1;
      cycle();
    end
    event_clr = '0;
    cycles(4);

    @(negedge clk);
    #1;
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/sync_edge_bank.md
Name: sync_edge_bank

Overview:
- Parametrised successor to the team's two-flop single-bit synchroniser. It lives entirely in the destination clock domain.
- Synchronises CH independent asynchronous single-bit inputs through a configurable STAGES-deep flop chain.
- Adds per-channel programmable edge detection, one-cycle event pulses and sticky event flags with software clear.
- Sits at the receive side of every control/status crossing; sources need no handshake.

Parameters:
- CH, 4, number of independent channels (>=1).
- STAGES, 2, synchroniser depth per channel (>=2; elaboration error if <2).
- RST_VAL, 1'b0, reset value of every synchroniser stage and of the level history.
- FILT_W, 4, width of the filter-length control.

Ports:
- clk  in  1  destination clock.
- rst_n  in  1  asynchronous, active-low reset.
- async_in  in  CH  asynchronous inputs, one bit per channel.
- edge_mode  in  2*CH  per channel [2c+1:2c]: 00 none, 01 rise, 10 fall, 11 both. Quasi-static.
- filt_len  in  FILT_W  debounce length; used only with the optional feature.
- event_clr  in  CH  per-channel clear of event_flag.
- sync_out  out  CH  synchronised (and filtered) level.
- edge_pulse  out  CH  one-cycle pulse per qualifying edge.
- event_flag  out  CH  sticky: set by edge_pulse, cleared by event_clr.

Behaviour:
- Reset (async assert, sync release by the system):
  - All sync stages, the level register and the previous-level register go to RST_VAL.
  - sync_out = RST_VAL.
  - edge_pulse = 0, event_flag = 0, filter counters = 0.
  - The first edge after reset release must not produce a spurious pulse.
- Sync chain: stage[0] samples async_in[c] on every posedge clk; stage[k] <= stage[k-1]. The chain carries no logic between stages.
- Level (feature off): lvl[c] = stage[STAGES-1]. sync_out is registered = lvl.
  - Latency: an input change stable before edge N appears on sync_out after edge N+STAGES-1.
  - An input changing within the setup window may add one cycle.
- Edge detect: prev[c] <= lvl[c] each cycle.
  - rise = lvl & ~prev; fall = ~lvl & prev.
  - edge_pulse[c] is registered, high for exactly one cycle when (rise & mode[0]) | (fall & mode[1]).
  - edge_pulse asserts in the cycle after sync_out changes.
  - mode 00 never pulses, but sync_out still tracks.
  - A mode change takes effect on the next cycle; no pulse is generated by the mode change itself.
- Sticky flag: event_flag[c] <= (event_flag[c] & ~event_clr[c]) | edge_pulse[c].
  - Set and clear in the same cycle: set wins, flag stays 1.
  - Clear while the flag is 0: no effect.
- Channels are fully independent. Simultaneous edges on all CH channels produce simultaneous pulses.
- An input toggling faster than the clock is undefined at the source. The block only guarantees no metastable value propagates past stage[1]. Pulses are one per observed level change, never merged across cycles.

Optional Feature:
- Macro: SYNC_EDGE_BANK_FILTER_EN.
- With the macro:
  - Per-channel counter cnt[c] of FILT_W bits sits between stage[STAGES-1] and lvl.
  - If stage[STAGES-1] == lvl: cnt <= 0.
  - Otherwise, if cnt == filt_len: lvl <= stage[STAGES-1] and cnt <= 0.
  - Otherwise cnt <= cnt+1.
  - Net effect: the new value must be seen on filt_len+1 consecutive cycles before lvl follows. filt_len = 0 adds exactly one cycle of latency.
  - A glitch shorter than filt_len+1 cycles resets the counter and produces no pulse.
  - The counter saturates at filt_len and never wraps.
  - Changing filt_len mid-count compares against the new value from the next cycle.
- Without the macro: no counters; filt_len is ignored but the port remains; latency is as above.

Decomposition:
- Shared package sync_pkg:
  - edge_mode_e enum (EDGE_NONE=2'b00, EDGE_RISE=2'b01, EDGE_FALL=2'b10, EDGE_BOTH=2'b11).
  - SYNC_MIN_STAGES = 2.
- Sub-module sync_chain: one-bit, STAGES-deep, parametrised RST_VAL. Instantiated CH times in a generate loop so the sync flops carry a recognisable instance name for CDC sign-off waivers.
- Filter and edge/flag logic stay in the top level.

Test Plan:
1. Reset: hold rst_n=0 with async_in=4'hF, release. Required: sync_out=0, edge_pulse=0 and event_flag=0 during reset. sync_out=4'hF after 2 edges. Exactly one rise pulse per channel whose mode is 01/11, and no pulse for mode 10.
2. Latency: CH=4, STAGES=2, mode=all 11. Set async_in[2] 0->1 one cycle before edge N. Required: sync_out[2]=1 after edge N+1, edge_pulse[2]=1 for the single cycle after edge N+2, event_flag[2] set.
3. Mode filtering: channel 0 mode 01, channel 1 mode 10. Drive rise then fall on both. Required: one pulse on ch0 (rise), one pulse on ch1 (fall), nothing else.
4. Sticky clear collision: assert event_clr[3] in the same cycle edge_pulse[3]=1. Required: event_flag[3] stays 1. A clear on the next cycle drives it to 0.
5. Filter (SYNC_EDGE_BANK_FILTER_EN, filt_len=3):
   - A 3-cycle high glitch on ch1 gives no sync_out change and no pulse.
   - A 4-cycle stable high sets sync_out[1] 4 cycles after the synchronised change, with one pulse.
6. Reset mid-operation: assert rst_n while ch0's filter counter=2 and event_flag=4'hA. Required: everything is immediately at reset values with no clock, and there is no pulse after release.
